// File: rtl/mu0_pkg.sv
// MU0 shared definitions: opcodes, alu16 modes and sequencer states.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_INC  = 2'b10;
  localparam logic [1:0] ALU_SUB  = 2'b11;

  localparam logic [1:0] JC_ALW = 2'd0;
  localparam logic [1:0] JC_GE  = 2'd1;
  localparam logic [1:0] JC_NE  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_RD,
    S_EXEC_WR,
    S_HALT
  } state_e;

endpackage

// File: rtl/mu0_decode.sv
// MU0 opcode decoder: one-hot instruction class plus jump condition.
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       is_rd_o,
  output logic       is_wr_o,
  output logic       is_jmp_o,
  output logic [1:0] jmp_cond_o,
  output logic       is_stp_o,
  output logic       is_ill_o
);

  always_comb begin
    is_rd_o    = 1'b0;
    is_wr_o    = 1'b0;
    is_jmp_o   = 1'b0;
    jmp_cond_o = JC_ALW;
    is_stp_o   = 1'b0;
    is_ill_o   = 1'b0;
    case (op_i)
      OP_LDA,
      OP_ADD,
      OP_SUB: is_rd_o = 1'b1;
      OP_STO: is_wr_o = 1'b1;
      OP_JMP: is_jmp_o = 1'b1;
      OP_JGE: begin
        is_jmp_o   = 1'b1;
        jmp_cond_o = JC_GE;
      end
      OP_JNE: begin
        is_jmp_o   = 1'b1;
        jmp_cond_o = JC_NE;
      end
      OP_STP: is_stp_o = 1'b1;
      default: is_ill_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 fetch/decode/execute controller; owns PC, IR, ACC and drives alu16.
module mu0_sequencer
  import mu0_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [1:0]        alu_m,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_z,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              illegal
);

  localparam int OP_W = DATA_W - ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ill_q, ill_d;

  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] pc_ext;
  logic              is_rd, is_wr, is_jmp, is_stp, is_ill;
  logic [1:0]        jmp_cond;
  logic              take;

  assign op     = ir_q[DATA_W-1:ADDR_W];
  assign opnd   = ir_q[ADDR_W-1:0];
  assign pc_ext = {{OP_W{1'b0}}, pc_q};

  mu0_decode u_dec (
    .op_i       (op),
    .is_rd_o    (is_rd),
    .is_wr_o    (is_wr),
    .is_jmp_o   (is_jmp),
    .jmp_cond_o (jmp_cond),
    .is_stp_o   (is_stp),
    .is_ill_o   (is_ill)
  );

  always_comb begin
    take = 1'b1;
    case (jmp_cond)
      JC_GE:   take = ~acc_q[DATA_W-1];
      JC_NE:   take = |acc_q;
      default: take = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      ill_q   <= ill_d;
    end
  end

  // Registers only move on the ack edge, so wait states are free.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = alu_z[ADDR_W-1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_rd:  state_d = S_EXEC_RD;
          is_wr:  state_d = S_EXEC_WR;
          is_jmp: begin
            if (take) pc_d = opnd;
            state_d = S_FETCH;
          end
          is_stp: state_d = S_HALT;
          is_ill: begin
            ill_d   = 1'b1;
            state_d = S_HALT;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_EXEC_RD: begin
        if (mem_ack) begin
          acc_d   = alu_z;
          state_d = S_FETCH;
        end
      end
      S_EXEC_WR: begin
        if (mem_ack) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    alu_m    = ALU_PASS;
    alu_x    = pc_ext;
    alu_y    = '0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alu_m   = ALU_INC;
      end
      S_EXEC_RD: begin
        mem_req  = 1'b1;
        mem_addr = opnd;
        alu_x    = acc_q;
        alu_y    = mem_rdata;
        if (op == OP_ADD)      alu_m = ALU_ADD;
        else if (op == OP_SUB) alu_m = ALU_SUB;
        else                   alu_m = ALU_PASS;
      end
      S_EXEC_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = opnd;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_wdata = acc_q;
  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Bench for mu0_sequencer: alu16 model, wait-state memory, bus scoreboard.
module tb_mu0_sequencer;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  alu_m;
  logic [15:0] alu_x, alu_y, alu_z;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] acc_out;
  logic [11:0] pc_out;
  logic        halted, illegal;

  logic        rst2_n = 1'b0;
  logic [1:0]  alu_m2;
  logic [15:0] alu_x2, alu_y2, alu_z2;
  logic        mem_req2, mem_we2, mem_ack2;
  logic [11:0] mem_addr2;
  logic [15:0] mem_wdata2, mem_rdata2;
  logic [15:0] acc_out2;
  logic [11:0] pc_out2;
  logic        halted2, illegal2;

  logic [15:0] mem [0:4095];
  txn_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          cyc;
  logic        held = 1'b0;
  logic [11:0] h_addr;
  logic        h_we;
  logic [15:0] h_acc;
  logic [11:0] h_pc;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu16(logic [1:0] m, logic [15:0] x,
                                        logic [15:0] y);
    case (m)
      2'b00:   return y;
      2'b01:   return x + y;
      2'b10:   return x + 16'd1;
      default: return x - y;
    endcase
  endfunction

  assign alu_z  = alu16(alu_m, alu_x, alu_y);
  assign alu_z2 = alu16(alu_m2, alu_x2, alu_y2);

  mu0_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .alu_m(alu_m), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .acc_out(acc_out), .pc_out(pc_out),
    .halted(halted), .illegal(illegal)
  );

  mu0_sequencer #(.RESET_PC(12'hFFF)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .alu_m(alu_m2), .alu_x(alu_x2), .alu_y(alu_y2), .alu_z(alu_z2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
    .acc_out(acc_out2), .pc_out(pc_out2),
    .halted(halted2), .illegal(illegal2)
  );

  // Zero-wait responder for the second instance.
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = mem[mem_addr2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(logic we, logic [11:0] a, logic [15:0] d);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.data = d;
    sbq.push_back(t);
  endtask

  // Memory responder on the falling edge; a transfer is scored when ack is granted.
  initial mem_ack = 1'b0;
  initial mem_rdata = '0;
  always @(negedge clk) begin
    if (held && rst_n) begin
      chk("hold_req", mem_req, 1'b1);
      chk("hold_addr", mem_addr, h_addr);
      chk("hold_we", mem_we, h_we);
      chk("hold_acc", acc_out, h_acc);
      chk("hold_pc", pc_out, h_pc);
    end
    held = 1'b0;
    if (rst_n && mem_req) begin
      if (wcnt >= wait_cfg) begin
        txn_t e;
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        wcnt = 0;
        if (sbq.size() == 0) begin
          chk("sb_unexpected", sbq.size() != 0, 1'b1);
        end else begin
          e = sbq.pop_front();
          chk("sb_we", mem_we, e.we);
          chk("sb_addr", mem_addr, e.addr);
          if (e.we) chk("sb_wdata", mem_wdata, e.data);
        end
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
        held = 1'b1;
        h_addr = mem_addr;
        h_we = mem_we;
        h_acc = acc_out;
        h_pc = pc_out;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic clr_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  task automatic do_reset(int w);
    @(negedge clk); #2;
    rst_n = 1'b0;
    wait_cfg = w;
    sbq.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_pc", pc_out, 12'h000);
    chk("rst_acc", acc_out, 16'h0000);
    chk("rst_halt", halted, 1'b0);
    chk("rst_ill", illegal, 1'b0);
  endtask

  task automatic release_rst();
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  initial begin
    clr_mem();

    // Reset release and ADD program
    do_reset(0);
    mem[12'h000] = 16'h000A;
    mem[12'h001] = 16'h200B;
    mem[12'h002] = 16'h100C;
    mem[12'h003] = 16'h7000;
    mem[12'h00A] = 16'h0005;
    mem[12'h00B] = 16'h0003;
    push(0, 12'h000, 0); push(0, 12'h00A, 0);
    push(0, 12'h001, 0); push(0, 12'h00B, 0);
    push(0, 12'h002, 0); push(1, 12'h00C, 16'h0008);
    push(0, 12'h003, 0);
    release_rst();
    #1;
    chk("idle_req", mem_req, 1'b0);
    chk("idle_acc", acc_out, 16'h0000);
    chk("idle_pc", pc_out, 12'h000);
    @(posedge clk); #1;
    chk("f0_req", mem_req, 1'b1);
    chk("f0_we", mem_we, 1'b0);
    chk("f0_addr", mem_addr, 12'h000);
    run_to_halt(200, cyc);
    chk("p1_cycles", cyc, 12);
    chk("p1_ill", illegal, 1'b0);
    chk("p1_pc", pc_out, 12'h004);
    chk("p1_acc", acc_out, 16'h0008);
    chk("p1_mem", mem[12'h00C], 16'h0008);
    repeat (4) @(negedge clk);
    chk("p1_noreq", mem_req, 1'b0);
    chk("p1_drain", sbq.size(), 0);

    // SUB to negative, JGE not taken, JNE taken
    do_reset(0);
    clr_mem();
    mem[12'h000] = 16'h000B;
    mem[12'h001] = 16'h300A;
    mem[12'h002] = 16'h5020;
    mem[12'h003] = 16'h6030;
    mem[12'h030] = 16'h7000;
    mem[12'h00A] = 16'h0005;
    mem[12'h00B] = 16'h0003;
    push(0, 12'h000, 0); push(0, 12'h00B, 0);
    push(0, 12'h001, 0); push(0, 12'h00A, 0);
    push(0, 12'h002, 0); push(0, 12'h003, 0);
    push(0, 12'h030, 0);
    release_rst();
    run_to_halt(200, cyc);
    chk("p2_cycles", cyc, 13);
    chk("p2_acc", acc_out, 16'hFFFE);
    chk("p2_pc", pc_out, 12'h031);
    chk("p2_drain", sbq.size(), 0);

    // Three wait states on every transfer
    do_reset(3);
    clr_mem();
    mem[12'h000] = 16'h000A;
    mem[12'h001] = 16'h7000;
    mem[12'h00A] = 16'h1234;
    push(0, 12'h000, 0); push(0, 12'h00A, 0); push(0, 12'h001, 0);
    release_rst();
    run_to_halt(200, cyc);
    chk("p3_cycles", cyc, 15);
    chk("p3_acc", acc_out, 16'h1234);
    chk("p3_pc", pc_out, 12'h002);
    chk("p3_drain", sbq.size(), 0);

    // Illegal opcode, then reset clears it
    do_reset(0);
    clr_mem();
    mem[12'h000] = 16'h9123;
    push(0, 12'h000, 0);
    release_rst();
    run_to_halt(50, cyc);
    chk("p4_cycles", cyc, 3);
    chk("p4_ill", illegal, 1'b1);
    chk("p4_pc", pc_out, 12'h001);
    chk("p4_drain", sbq.size(), 0);
    do_reset(0);
    mem[12'h000] = 16'h7000;
    push(0, 12'h000, 0);
    release_rst();
    run_to_halt(50, cyc);
    chk("p4b_ill", illegal, 1'b0);
    chk("p4b_pc", pc_out, 12'h001);
    chk("p4b_drain", sbq.size(), 0);

    // RESET_PC=FFF wraps to 000 after fetch
    do_reset(0);
    clr_mem();
    mem[12'hFFF] = 16'h0001;
    mem[12'h001] = 16'hABCD;
    mem[12'h000] = 16'h7000;
    @(negedge clk); #2;
    chk("w_rst_pc", pc_out2, 12'hFFF);
    rst2_n = 1'b1;
    cyc = 0;
    while (!halted2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("w_halt", halted2, 1'b1);
    chk("w_cycles", cyc, 6);
    chk("w_pc", pc_out2, 12'h001);
    chk("w_acc", acc_out2, 16'hABCD);
    chk("w_ill", illegal2, 1'b0);
    @(negedge clk); #2;
    rst2_n = 1'b0;

    // Reset mid store abandons the transfer
    do_reset(2);
    clr_mem();
    mem[12'h000] = 16'h000A;
    mem[12'h001] = 16'h100C;
    mem[12'h00A] = 16'h0042;
    push(0, 12'h000, 0); push(0, 12'h00A, 0); push(0, 12'h001, 0);
    release_rst();
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("ab_inwr", mem_req && mem_we, 1'b1);
    chk("ab_acc_pre", acc_out, 16'h0042);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab_req", mem_req, 1'b0);
    chk("ab_acc", acc_out, 16'h0000);
    chk("ab_pc", pc_out, 12'h000);
    repeat (2) @(negedge clk);
    chk("ab_mem", mem[12'h00C], 16'h0000);
    chk("ab_drain", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
